// File: rtl/cnn_window_generator.sv
// Streaming KX x KY sliding-window generator: KY-1 line buffers plus a window register per channel.
// Optional macro CNN_WIN_DEBUG_CNT_EN enables the per-frame window counter on win_cnt.
module cnn_window_generator #(
    parameter int CI     = 3,
    parameter int KX     = 5,
    parameter int KY     = 5,
    parameter int IX     = 28,
    parameter int IY     = 28,
    parameter int I_F_BW = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         soft_rst,
    input  logic                         in_valid,
    input  logic [CI*I_F_BW-1:0]         in_pixel,
    output logic                         data_valid,
    output logic [CI*KX*KY*I_F_BW-1:0]   feature_map,
    output logic                         frame_done,
    output logic [15:0]                  win_cnt
);

    localparam int PW = CI * I_F_BW;
    localparam int FW = CI * KX * KY * I_F_BW;
    localparam int CW = (IX > 1) ? $clog2(IX) : 1;
    localparam int RW = (IY > 1) ? $clog2(IY) : 1;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t                         state, state_nxt;
    logic [CW-1:0]                  col, col_nxt;
    logic [RW-1:0]                  row, row_nxt;
    logic                           accept, last_px, emit;

    logic [IX-1:0][PW-1:0]          lb [KY-1];
    logic [KY-1:0][PW-1:0]          col_new;
    logic [KY-1:0][KX-1:0][PW-1:0]  win, win_nxt;
    logic [FW-1:0]                  fm_nxt;

    // A pixel arriving together with soft_rst is dropped.
    assign accept  = in_valid && !soft_rst;
    assign last_px = (row == RW'(IY-1)) && (col == CW'(IX-1));
    assign emit    = accept && (row >= RW'(KY-1)) && (col >= CW'(KX-1));

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        if (soft_rst) begin
            state_nxt = IDLE;
            col_nxt   = '0;
            row_nxt   = '0;
        end else if (in_valid) begin
            if (last_px) begin
                col_nxt = '0;
                row_nxt = '0;
            end else if (col == CW'(IX-1)) begin
                col_nxt = '0;
                row_nxt = row + 1'b1;
            end else begin
                col_nxt = col + 1'b1;
            end
            case (state)
                IDLE:    state_nxt = FILL;
                FILL:    if (row == RW'(KY-1) && col == '0) state_nxt = RUN;
                RUN:     if (last_px) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Line buffer j delays by (j+1)*IX accepted pixels; lb[KY-2] feeds the top tap row.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0] <= {lb[0][IX-2:0], in_pixel};
            for (int j = 1; j < KY-1; j++)
                lb[j] <= {lb[j][IX-2:0], lb[j-1][IX-1]};
        end
    end

    always_comb begin
        col_new        = '0;
        col_new[KY-1]  = in_pixel;
        for (int j = 0; j < KY-1; j++)
            col_new[KY-2-j] = lb[j][IX-1];
        win_nxt = '0;
        for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX-1; kx++)
                win_nxt[ky][kx] = win[ky][kx+1];
            win_nxt[ky][KX-1] = col_new[ky];
        end
    end

    genvar gc, gy, gx;
    generate
        for (gc = 0; gc < CI; gc++) begin : g_ch
            for (gy = 0; gy < KY; gy++) begin : g_ky
                for (gx = 0; gx < KX; gx++) begin : g_kx
                    assign fm_nxt[(gc*KX*KY + gy*KX + gx)*I_F_BW +: I_F_BW] =
                        win_nxt[gy][gx][gc*I_F_BW +: I_F_BW];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            win         <= '0;
            data_valid  <= 1'b0;
            frame_done  <= 1'b0;
            feature_map <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
            if (soft_rst) begin
                data_valid <= 1'b0;
                frame_done <= 1'b0;
            end else begin
                data_valid <= emit;
                frame_done <= emit && last_px;
            end
            if (accept) win <= win_nxt;
            if (emit) feature_map <= fm_nxt;
        end
    end

`ifdef CNN_WIN_DEBUG_CNT_EN
    logic [15:0] cnt;
    // The first pixel of a frame restarts the count, so it reads the total through the frame_done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (soft_rst)
            cnt <= '0;
        else if (accept)
            cnt <= ((row == '0 && col == '0) ? 16'd0 : cnt) + 16'(emit);
    end
    assign win_cnt = cnt;
`else
    assign win_cnt = '0;
`endif

endmodule

// File: tb/tb_cnn_window_generator.sv
// Randomized bench for cnn_window_generator with a frame-image reference model and per-cycle compare.
// Expected win_cnt follows the CNN_WIN_DEBUG_CNT_EN macro.
module tb_cnn_window_generator;

    localparam int CI = 2, KX = 3, KY = 3, IX = 8, IY = 6, BW = 8;
    localparam int PW = CI * BW;
    localparam int FW = CI * KX * KY * BW;
    localparam int NPX = IX * IY;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          soft_rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_pixel = '0;
    logic          data_valid, frame_done;
    logic [FW-1:0] feature_map;
    logic [15:0]   win_cnt;

    cnn_window_generator #(.CI(CI), .KX(KX), .KY(KY), .IX(IX), .IY(IY), .I_F_BW(BW)) dut (
        .clk(clk), .rst(rst), .soft_rst(soft_rst), .in_valid(in_valid), .in_pixel(in_pixel),
        .data_valid(data_valid), .feature_map(feature_map), .frame_done(frame_done), .win_cnt(win_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Reference model: the frame image plus the position of the next pixel within it.
    logic [PW-1:0] img [IY][IX];
    int            mn = 0;
    int            wcnt = 0;
    logic [FW-1:0] m_fm = '0;
    logic          exp_dv = 1'b0, exp_fd = 1'b0;
    logic [FW-1:0] exp_fm = '0;
    int            exp_wc = 0;

    logic [FW-1:0] caps[$], ref_caps[$];
    int            fd_idx[$], fd_wc[$];
    int            px_acc = 0, first_acc = -1;

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, expv);
        end
    endtask

    task automatic chki(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, expv);
        end
    endtask

    function automatic logic [7:0] tap(input logic [FW-1:0] fm, input int ch, input int ky, input int kx);
        return fm[(ch*KX*KY + ky*KX + kx)*BW +: BW];
    endfunction

    function automatic logic [PW-1:0] std_pix(input int k);
        logic [7:0] v;
        v = 8'(k);
        return {8'd128 + v, v};
    endfunction

    // Apply one cycle of inputs; the model predicts what the outputs must show after the edge.
    task automatic step(input logic v, input logic [PW-1:0] pix, input logic srst);
        logic ndv, nfd;
        int   r, c;
        in_valid = v; in_pixel = pix; soft_rst = srst;
        ndv = 1'b0; nfd = 1'b0;
        if (srst) begin
            mn = 0; wcnt = 0;
        end else if (v) begin
            r = mn / IX; c = mn % IX;
            img[r][c] = pix;
            if (mn == 0) wcnt = 0;
            if (r >= KY-1 && c >= KX-1) begin
                for (int ch = 0; ch < CI; ch++)
                    for (int ky = 0; ky < KY; ky++)
                        for (int kx = 0; kx < KX; kx++)
                            m_fm[(ch*KX*KY + ky*KX + kx)*BW +: BW] = img[r-KY+1+ky][c-KX+1+kx][ch*BW +: BW];
                ndv = 1'b1;
                nfd = (mn == NPX-1);
                wcnt++;
            end
            mn = (mn + 1) % NPX;
        end
        @(posedge clk); #1;
        exp_dv = ndv; exp_fd = nfd; exp_fm = m_fm;
`ifdef CNN_WIN_DEBUG_CNT_EN
        exp_wc = wcnt;
`else
        exp_wc = 0;
`endif
        if (v && !srst) px_acc++;
        in_valid = 1'b0; soft_rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic feed(input int cnt, input int gap_pct, input bit rnd);
        for (int i = 0; i < cnt; i++) begin
            while ($urandom_range(99) < gap_pct) step(1'b0, PW'($urandom), 1'b0);
            step(1'b1, rnd ? PW'($urandom) : std_pix(mn), 1'b0);
        end
    endtask

    task automatic clear_caps();
        caps.delete(); fd_idx.delete(); fd_wc.delete();
        px_acc = 0; first_acc = -1;
    endtask

    task automatic match_ref(input string nm);
        chki({nm, "_count"}, caps.size(), ref_caps.size());
        for (int i = 0; i < caps.size() && i < ref_caps.size(); i++)
            chk(nm, caps[i], ref_caps[i]);
    endtask

    // Per-cycle compare against the model, plus capture of emitted windows.
    always @(negedge clk) begin
        chk("data_valid", FW'(data_valid), FW'(exp_dv));
        chk("frame_done", FW'(frame_done), FW'(exp_fd));
        chk("feature_map", feature_map, exp_fm);
        chki("win_cnt", int'(win_cnt), exp_wc);
        if (data_valid) begin
            caps.push_back(feature_map);
            if (caps.size() == 1) first_acc = px_acc;
        end
        if (frame_done) begin
            fd_idx.push_back(caps.size());
            fd_wc.push_back(int'(win_cnt));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("reset_dv", FW'(data_valid), '0);
        chk("reset_fm", feature_map, '0);
        chki("reset_wc", int'(win_cnt), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Continuous frame
        clear_caps();
        feed(NPX, 0, 0);
        idle(3);
        chki("s1_count", caps.size(), 24);
        chki("s1_first_at", first_acc, 19);
        if (caps.size() == 24) begin
            chki("s1_c0_t00", tap(caps[0], 0, 0, 0), 0);
            chki("s1_c0_t02", tap(caps[0], 0, 0, 2), 2);
            chki("s1_c0_t22", tap(caps[0], 0, 2, 2), 18);
            chki("s1_c1_t00", tap(caps[0], 1, 0, 0), 128);
            chki("s1_row3_t00", tap(caps[6], 0, 0, 0), 8);
            chki("s1_last_t22", tap(caps[23], 0, 2, 2), 47);
        end
        chki("s1_fd_pulses", fd_idx.size(), 1);
        if (fd_idx.size() > 0) chki("s1_fd_at", fd_idx[0], 24);
        ref_caps = caps;

        // Random in_valid gaps
        clear_caps();
        feed(NPX, 50, 0);
        idle(3);
        match_ref("s2_win");
        chki("s2_fd_pulses", fd_idx.size(), 1);
        if (fd_idx.size() > 0) chki("s2_fd_at", fd_idx[0], 24);

        // soft_rst mid-frame, dropping pixel 30, then a fresh frame
        clear_caps();
        feed(30, 0, 0);
        step(1'b1, std_pix(30), 1'b1);
        clear_caps();
        feed(NPX, 0, 0);
        idle(3);
        match_ref("s3_win");
        chki("s3_first_at", first_acc, 19);

        // Two back-to-back frames
        clear_caps();
        feed(2*NPX, 0, 0);
        idle(3);
        chki("s4_count", caps.size(), 48);
        chki("s4_fd_pulses", fd_idx.size(), 2);
        if (fd_idx.size() == 2) begin
            chki("s4_fd0_at", fd_idx[0], 24);
            chki("s4_fd1_at", fd_idx[1], 48);
`ifdef CNN_WIN_DEBUG_CNT_EN
            chki("s4_wc0", fd_wc[0], 24);
            chki("s4_wc1", fd_wc[1], 24);
`else
            chki("s4_wc0", fd_wc[0], 0);
            chki("s4_wc1", fd_wc[1], 0);
`endif
        end

        // Random data with gaps, checked cycle by cycle against the model
        clear_caps();
        feed(NPX, 30, 1);
        idle(3);
        chki("s5_count", caps.size(), 24);

        // Asynchronous rst right after a window is emitted
        clear_caps();
        feed(22, 0, 0);
        chki("s6_dv_before", int'(data_valid), 1);
        rst = 1'b1;
        mn = 0; wcnt = 0; m_fm = '0;
        exp_dv = 1'b0; exp_fd = 1'b0; exp_fm = '0; exp_wc = 0;
        #1;
        chk("s6_rst_dv", FW'(data_valid), '0);
        chk("s6_rst_fm", feature_map, '0);
        chki("s6_rst_wc", int'(win_cnt), 0);
        idle(2);
        rst = 1'b0;
        clear_caps();
        feed(NPX, 0, 0);
        idle(3);
        match_ref("s6_win");
        chki("s6_first_at", first_acc, 19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cnn_window_generator.md
# cnn_window_generator

Streaming sliding-window generator feeding the convolution channel accumulator of a CNN layer. Accepts one multi-channel pixel per cycle in raster order and builds KY-1 line buffers plus a KX×KY window register per channel. For every stride-1 valid window position it emits a full CI×KX×KY window on `feature_map` with a one-cycle `data_valid` strobe, packed exactly as the accumulator consumes it.

## Interface
- `CI`, 3: input channels
- `KX`, 5: kernel width
- `KY`, 5: kernel height
- `IX`, 28: image width in pixels
- `IY`, 28: image height in pixels
- `I_F_BW`, 8: pixel bit width
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `soft_rst` in 1: synchronous clear, active-high
- `in_valid` in 1: pixel strobe, at most one pixel per cycle; no backpressure
- `in_pixel` in CI*I_F_BW: channel c at `[c*I_F_BW +: I_F_BW]`
- `data_valid` out 1: window strobe, one cycle per window
- `feature_map` out CI*KX*KY*I_F_BW: tap (c,ky,kx) at `[(c*KX*KY + ky*KX + kx)*I_F_BW +: I_F_BW]`
- `frame_done` out 1: one-cycle pulse, coincident with the frame's last `data_valid`
- `win_cnt` out 16: windows emitted in current frame (see Configuration)

## Operation
- Counters: `col` 0..IX-1 and `row` 0..IY-1, advance only on `in_valid`. `col` wraps to 0 and increments `row`. Frame end at (IY-1, IX-1).
- Line buffers: KY-1 shift rows of IX entries, each CI*I_F_BW wide, shifting on `in_valid`. Window registers shift left on `in_valid`; the new column is {line buffers oldest→newest, `in_pixel`}.
- Tap orientation: kx=0 is the oldest (leftmost) column; ky=0 is the oldest (top) row; tap (KY-1,KX-1) is the pixel just accepted.
- State machine:
  - IDLE: counters zero. Accepted pixel → FILL.
  - FILL: pixel accepted with row==KY-1 and col==0 → RUN.
  - RUN: emits windows. Accepting (IY-1, IX-1) → IDLE; counters reset to 0.
- Window emitted when a pixel is accepted with row≥KY-1 and col≥KX-1. No windows straddle a row wrap. Total per frame: (IX-KX+1)*(IY-KY+1), default 576.
- `in_valid` low: all state, counters and window registers hold.
- `soft_rst`: state→IDLE; counters, `data_valid`, `frame_done`, `win_cnt` → 0; line buffer contents are not cleared. `soft_rst` has priority over a simultaneous `in_valid`; that pixel is dropped.
- `rst` mid-frame: same clears, asynchronously; the next pixel is treated as (0,0).
- Pixel data is passed through unmodified; no arithmetic.

## Timing
- Reset values: `data_valid`=0, `frame_done`=0, `feature_map`=0, `win_cnt`=0, state IDLE.
- Latency: `data_valid`/`feature_map` are registered one cycle after the accepted pixel completing the window. `feature_map` holds until the next window.
- Back-to-back `in_valid` yields back-to-back `data_valid` within a row. There is a gap of KX-1 accepted pixels at each row start.
- A frame's last pixel, followed immediately by the next frame's first pixel, is legal with no bubble.

## Configuration
- `CNN_WIN_DEBUG_CNT_EN`
  - Defined: `win_cnt` increments with each `data_valid`. It reads the total (576 by default) in the `frame_done` cycle and clears to 0 on the next accepted pixel or on reset/`soft_rst`.
  - Undefined: `win_cnt` is tied to 0 and no counter logic is generated.

## Test plan
Bench config: CI=2, KX=KY=3, IX=8, IY=6, I_F_BW=8. Stimulus: ch0 = r*8+c, ch1 = 128+r*8+c.
- Continuous frame → first `data_valid` the cycle after pixel 18 is accepted. ch0 taps (0,0)=0, (0,2)=2, (2,2)=18. ch1 tap (0,0)=128. Exactly 24 strobes.
- Row transition → no `data_valid` for pixels (3,0),(3,1). Window at (3,2) has ch0 tap (0,0)=8.
- Random `in_valid` gaps (~50%) → identical 24-window sequence as the continuous case; `frame_done` coincides with window 24, whose tap (2,2)=47.
- `soft_rst` asserted at pixel 30 of a frame, then a fresh frame → no stale windows. First window again after the 19th new pixel, matching the first scenario.
- Two back-to-back frames with no bubble → 48 windows, two `frame_done` pulses. With the macro defined, `win_cnt`=24 at each pulse.
- `rst` pulsed mid-RUN → outputs 0 immediately. Next frame behaves as the first scenario.
